// File: rtl/i2c_pkg.sv
// Shared I2C constants and target state encoding for the
// IS31 LED-driver target and the controller-side sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_LOC,
    S_LOC_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } i2c_target_state_t;

  localparam logic [7:0] CMD_LOC_DEFAULT = 8'hFD;
  localparam logic [7:0] PAGE_FUNCTION   = 8'h0B;
  localparam logic [7:0] PAGE_FRAME_1    = 8'h00;
  localparam logic [7:0] LED_CTRL_OFFSET = 8'h00;
  localparam logic [7:0] PWM_OFFSET      = 8'h24;

endpackage

// File: rtl/i2c_line_conditioner.sv
// Synchronizes and deglitches SCL/SDA, then flags SCL edges
// and START/STOP conditions on the filtered levels.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic [CW-1:0] scl_cnt_q;
  logic [CW-1:0] sda_cnt_q;
  logic scl_f_q, sda_f_q;
  logic scl_p_q, sda_p_q;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end

  // Reset adopts the live bus level so a mid-transfer reset
  // cannot manufacture a START/STOP on release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_f_q   <= scl_s;
      sda_f_q   <= sda_s;
      scl_p_q   <= scl_s;
      sda_p_q   <= sda_s;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
      if (scl_s == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_s;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + CW'(1);
      end
      if (sda_s == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_s;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + CW'(1);
      end
    end
  end

  assign scl_f    = scl_f_q;
  assign sda_f    = sda_f_q;
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

endmodule

// File: rtl/i2c_target_is31.sv
// I2C target modelling the IS31 LED driver register interface:
// page register, auto-incrementing pointer, write strobes, reads.
module i2c_target_is31
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h74,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3,
  parameter logic [7:0] CMD_LOC     = CMD_LOC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_e,
  output logic       wr_en,
  output logic [7:0] wr_page,
  output logic [7:0] wr_loc,
  output logic [7:0] wr_data,
  output logic [7:0] rd_loc,
  input  logic [7:0] rd_data,
  output logic [7:0] page,
  output logic       busy,
  output logic       start_pulse,
  output logic       stop_pulse
);

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  logic drv_edge, last_bit;
  logic [7:0] byte_in;

  i2c_target_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rd_loc_q, rd_loc_d;
  logic [7:0] page_q, page_d;
  logic [7:0] wr_page_q, wr_page_d;
  logic [7:0] wr_loc_q, wr_loc_d;
  logic rw_q, rw_d;
  logic busy_q, busy_d;
  logic sda_e_q, sda_e_d;
  logic load_q, load_d;
  logic wr_en_q, wr_en_d;
  logic start_q, stop_q;

  i2c_line_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_cond (
    .clk     (clk),
    .reset_n (reset_n),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .scl_f   (scl_f),
    .sda_f   (sda_f),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  assign drv_edge = scl_fall & ~scl_f;
  assign byte_in  = {shift_q[6:0], sda_f};
  assign last_bit = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rd_loc_d  = rd_loc_q;
    page_d    = page_q;
    wr_page_d = wr_page_q;
    wr_loc_d  = wr_loc_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    sda_e_d   = sda_e_q;
    load_d    = load_q;
    wr_en_d   = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      sda_e_d = 1'b0;
    end else if (start) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      sda_e_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            if (byte_in[7:1] == ADDRESS) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        // First fall after bit 8 pulls ACK, the next one ends it.
        S_ADDR_ACK: if (drv_edge) begin
          if (!sda_e_q) begin
            sda_e_d = 1'b1;
          end else if (rw_q) begin
            state_d   = S_RDATA;
            shift_d   = rd_data;
            sda_e_d   = ~rd_data[7];
            load_d    = 1'b0;
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = S_LOC;
            sda_e_d   = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        S_LOC: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            rd_loc_d = byte_in;
            state_d  = S_LOC_ACK;
          end
        end
        S_LOC_ACK, S_WDATA_ACK: if (drv_edge) begin
          if (!sda_e_q) begin
            sda_e_d = 1'b1;
          end else begin
            state_d   = S_WDATA;
            sda_e_d   = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        S_WDATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            if (rd_loc_q == CMD_LOC) begin
              page_d = byte_in;
            end else begin
              wr_en_d   = 1'b1;
              wr_page_d = page_q;
              wr_loc_d  = rd_loc_q;
            end
            rd_loc_d = rd_loc_q + 8'd1;
            state_d  = S_WDATA_ACK;
          end
        end
        S_RDATA: begin
          if (drv_edge) begin
            if (load_q) begin
              shift_d = rd_data;
              sda_e_d = ~rd_data[7];
              load_d  = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sda_e_d = ~shift_q[6];
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) state_d = S_RDATA_ACK;
          end
        end
        S_RDATA_ACK: begin
          if (drv_edge) begin
            sda_e_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f) begin
              rd_loc_d  = rd_loc_q + 8'd1;
              load_d    = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = S_RDATA;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_IGNORE: sda_e_d = 1'b0;
        default: begin
          state_d = S_IDLE;
          sda_e_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      rd_loc_q  <= 8'h00;
      page_q    <= 8'h00;
      wr_page_q <= 8'h00;
      wr_loc_q  <= 8'h00;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_e_q   <= 1'b0;
      load_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rd_loc_q  <= rd_loc_d;
      page_q    <= page_d;
      wr_page_q <= wr_page_d;
      wr_loc_q  <= wr_loc_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      sda_e_q   <= sda_e_d;
      load_q    <= load_d;
      wr_en_q   <= wr_en_d;
      start_q   <= start;
      stop_q    <= stop;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_e       = sda_e_q;
  assign wr_en       = wr_en_q;
  assign wr_page     = wr_page_q;
  assign wr_loc      = wr_loc_q;
  assign wr_data     = shift_q;
  assign rd_loc      = rd_loc_q;
  assign page        = page_q;
  assign busy        = busy_q;
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;

endmodule
